// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU, shifts, HI/LO moves and iterative DIV/DIVU.
// Define EX_SIGNED_DIV_EN for signed DIV on op F; otherwise op F runs as DIVU.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  alu_op,
  input  logic [31:0] reg1_data,
  input  logic [31:0] reg2_data,
  input  logic [4:0]  dest_addr,
  input  logic        dest_en,
  output logic [4:0]  out_addr,
  output logic        out_en,
  output logic [31:0] out_data,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_ADDU = 4'h5;
  localparam logic [3:0] OP_SUBU = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLTU = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;
  localparam logic [3:0] OP_MFHI = 4'hC;
  localparam logic [3:0] OP_MFLO = 4'hD;
  localparam logic [3:0] OP_DIVU = 4'hE;
  localparam logic [3:0] OP_DIV  = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] alu_res;
  logic [31:0] a_mag, b_mag;
  logic [31:0] hi_fix, lo_fix;
  logic [31:0] step_rem, step_quo;
  logic [32:0] trial, diff;
  logic [4:0]  shamt;
  logic        div_op;
  logic        div_zero;

  assign div_op   = (alu_op == OP_DIVU) || (alu_op == OP_DIV);
  assign div_zero = (reg2_data == 32'd0);
  assign shamt    = reg1_data[4:0];
  assign hi       = hi_q;
  assign lo       = lo_q;

`ifdef EX_SIGNED_DIV_EN
  logic is_sdiv, sign_a, sign_b;
  logic neg_q_q, neg_r_q;

  assign is_sdiv = (alu_op == OP_DIV);
  assign sign_a  = is_sdiv && reg1_data[31];
  assign sign_b  = is_sdiv && reg2_data[31];
  assign a_mag   = sign_a ? -reg1_data : reg1_data;
  assign b_mag   = sign_b ? -reg2_data : reg2_data;
  assign hi_fix  = neg_r_q ? -rem_q : rem_q;
  assign lo_fix  = neg_q_q ? -quo_q : quo_q;
`else
  assign a_mag  = reg1_data;
  assign b_mag  = reg2_data;
  assign hi_fix = rem_q;
  assign lo_fix = quo_q;
`endif

  // One restoring step: shift rem:quo left, keep the trial difference if non-negative.
  always_comb begin
    trial    = {rem_q, quo_q[31]};
    diff     = trial - {1'b0, dvs_q};
    step_rem = trial[31:0];
    step_quo = {quo_q[30:0], 1'b0};
    if (!diff[32]) begin
      step_rem = diff[31:0];
      step_quo = {quo_q[30:0], 1'b1};
    end
  end

  // Single-cycle ALU, shift and HI/LO move results.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_AND:  alu_res = reg1_data & reg2_data;
      OP_OR:   alu_res = reg1_data | reg2_data;
      OP_XOR:  alu_res = reg1_data ^ reg2_data;
      OP_NOR:  alu_res = ~(reg1_data | reg2_data);
      OP_ADDU: alu_res = reg1_data + reg2_data;
      OP_SUBU: alu_res = reg1_data - reg2_data;
      OP_SLT:  alu_res = {31'd0, $signed(reg1_data) < $signed(reg2_data)};
      OP_SLTU: alu_res = {31'd0, reg1_data < reg2_data};
      OP_SLL:  alu_res = reg2_data << shamt;
      OP_SRL:  alu_res = reg2_data >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(reg2_data) >>> shamt);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Outputs to EX/MEM and the stall request, all blanked while reset is high.
  always_comb begin
    out_addr  = '0;
    out_en    = 1'b0;
    out_data  = '0;
    stall_req = 1'b0;
    if (!reset) begin
      out_addr  = dest_addr;
      out_en    = dest_en && !div_op && (alu_op != OP_NOP);
      out_data  = div_op ? 32'd0 : alu_res;
      stall_req = ((state_q == IDLE) && div_op) || (state_q == BUSY);
    end
  end

  // Divider next-state: DONE always returns to IDLE so the held op is not re-issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (div_op) state_d = div_zero ? DONE : BUSY;
      BUSY: if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Divider datapath and the architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef EX_SIGNED_DIV_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (div_op) begin
            cnt_q <= '0;
            dvs_q <= b_mag;
            if (div_zero) begin
              rem_q <= reg1_data;
              quo_q <= '1;
            end else begin
              rem_q <= '0;
              quo_q <= a_mag;
            end
`ifdef EX_SIGNED_DIV_EN
            neg_q_q <= !div_zero && (sign_a ^ sign_b);
            neg_r_q <= !div_zero && sign_a;
`endif
          end
        end
        BUSY: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits between the ID/EX pipeline register and the EX/MEM pipeline register, and drives that register's out_addr/out_en/out_data inputs.
- Performs single-cycle ALU/shift ops and HI/LO moves.
- Performs 32-cycle iterative DIV/DIVU. While a divide runs it raises stall_req.
- Owns the architectural HI/LO registers.

Parameters:
- DIV_CYCLES, 32, number of BUSY iterations of the restoring divider. Must equal the data width; fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- alu_op  in  4  operation code (see Behaviour)
- reg1_data  in  32  operand A (dividend; shift amount in [4:0])
- reg2_data  in  32  operand B (divisor; shifted value)
- dest_addr  in  5  destination register address
- dest_en  in  1  destination write enable from decode
- out_addr  out  5  to EX/MEM register
- out_en  out  1  to EX/MEM register
- out_data  out  32  to EX/MEM register
- stall_req  out  1  request to freeze PC, IF/ID and ID/EX; combinational
- hi  out  32  current HI register
- lo  out  32  current LO register

Behaviour:
- Opcodes: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 ADDU, 6 SUBU, 7 SLT (signed), 8 SLTU, 9 SLL, A SRL, B SRA, C MFHI, D MFLO, E DIVU, F DIV.
- Shifts:
  - shift reg2_data by reg1_data[4:0].
  - SRA sign-fills from reg2_data[31].
- Arithmetic: ADDU/SUBU wrap modulo 2^32 with no overflow trap. SLT/SLTU produce 0 or 1.
- Single-cycle ops (0-D): out_* are combinational in the same cycle.
  - out_addr = dest_addr
  - out_en = dest_en, except NOP forces out_en = 0
  - out_data = result
- DIV/DIVU: out_en = 0 and out_data = 0 in every cycle; the result goes only to HI/LO.
- Reset asserted: the following are forced 0 combinationally, and take effect in the same cycle:
  - out_en, out_data, out_addr, stall_req
- Reset at the clock edge: hi = lo = 0 and the FSM goes to IDLE. This includes reset mid-divide, which discards the divide.
- Divider FSM states: IDLE, BUSY, DONE.
- IDLE with op E/F:
  - stall_req = 1.
  - Latch magnitudes of dividend and divisor. DIV uses |x|; DIVU uses the raw value.
  - Latch sign flags.
  - Divisor != 0: go to BUSY with counter = 0.
  - Divisor == 0: go directly to DONE.
- BUSY:
  - stall_req = 1.
  - Each cycle performs one restoring-division step (shift remainder:quotient left, trial-subtract divisor) and increments the counter.
  - After the step with counter == 31, go to DONE. BUSY therefore lasts exactly 32 cycles.
- DONE:
  - stall_req = 0.
  - At the end of the cycle, write HI = remainder and LO = quotient, then go to IDLE.
  - The ID/EX register advances on that same edge.
  - The op still visible on the inputs in DONE is not re-issued.
- Sign fix for DIV:
  - quotient is negated if the operand signs differ.
  - remainder takes the sign of the dividend.
- Divide by zero, both ops: LO = 0xFFFFFFFF, HI = dividend (raw reg1_data).
- Totals:
  - normal divide: stall_req high for 33 consecutive cycles (issue + 32 BUSY), then 1 DONE cycle.
  - divide by zero: stall_req high for 1 cycle.
- Upstream must hold alu_op, operands and dest_* stable while stall_req = 1. The operands are latched at issue, so later changes are don't-care.
- MFHI/MFLO issued in the cycle after DONE read the new HI/LO; no extra forwarding is needed.

Optional Feature:
- Macro: EX_SIGNED_DIV_EN.
- Defined: op F performs the signed DIV described above.
- Undefined:
  - op F is executed identically to DIVU (unsigned).
  - the sign-correction and negation logic is not synthesised.
  - all other timing is unchanged.

Test Plan:
- Reset: assert reset for 2 cycles with op=5, dest_en=1 -> out_en=0, out_data=0, stall_req=0, hi=lo=0.
- ALU: op=5, A=0xFFFFFFFF, B=2, dest_addr=3, dest_en=1 -> out_data=1, out_addr=3, out_en=1. Then op=B, A=4, B=0x80000000 -> out_data=0xF8000000.
- DIVU: A=100, B=7 -> stall_req high 33 cycles, then DONE. Next cycle hi=2, lo=14. Then MFLO -> out_data=14.
- DIV (macro defined): A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. With macro undefined: lo=0x7FFFFFFC, hi=1.
- Divide by zero: A=0x1234, B=0, op=E -> stall_req high exactly 1 cycle; after DONE hi=0x1234, lo=0xFFFFFFFF.
- Reset mid-divide: assert reset at BUSY cycle 10 -> stall_req=0 next cycle, hi/lo=0. A fresh DIVU 9/3 then gives lo=3, hi=0 after 33 stall cycles.
